data_ram_pipe: RTL and testbench

DATA_RAM_PIPE -- requirements
Module: data_ram_pipe

---
 rtl/data_ram_pipe_if.sv | 19 +
 rtl/data_ram_pipe.sv | 49 ++++
 tb/tb_data_ram_pipe.sv | 128 ++++++++++++
 3 files changed

// File: rtl/data_ram_pipe_if.sv
// data_ram_pipe_if: request/response bus of the pipelined byte-lane data RAM
interface data_ram_pipe_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   localparam int BYTES = DATA_W / 8;
   logic              ce;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [BYTES-1:0]  sel;
   logic [DATA_W-1:0] data_i;
   logic              req_ready;
   logic              rvalid;
   logic              resp_ready;
   logic [DATA_W-1:0] data_o;
   logic              err;
   modport master (output ce, we, addr, sel, data_i, resp_ready, input req_ready, rvalid, data_o, err);
   modport slave  (input ce, we, addr, sel, data_i, resp_ready, output req_ready, rvalid, data_o, err);
endinterface

// File: rtl/data_ram_pipe.sv
// data_ram_pipe: byte-lane RAM with one-deep registered response and ready/valid flow control
module data_ram_pipe #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 32,
   parameter int DEPTH_LOG2 = 10
) (
   input logic             clk,
   input logic             rst,
   data_ram_pipe_if.slave  bus
);
   localparam int BYTES = DATA_W / 8;
   localparam int BL    = $clog2(BYTES);
   localparam int WORDS = 1 << DEPTH_LOG2;
   typedef enum logic {IDLE, FULL} state_t;
   state_t                    r_state;
   logic [DATA_W-1:0]         r_data;
   logic                      r_err;
   logic [BYTES-1:0][7:0]     r_mem [WORDS];
   logic [DEPTH_LOG2-1:0]     w_idx;
   logic                      w_oor;
   logic                      w_acc;
   assign w_idx         = bus.addr[DEPTH_LOG2+BL-1:BL];
   assign w_oor         = (bus.addr >> (DEPTH_LOG2 + BL)) != '0;
   assign bus.req_ready = !rst && (r_state == IDLE || bus.resp_ready);
   assign w_acc         = bus.ce && bus.req_ready;
   assign bus.rvalid    = r_state == FULL;
   assign bus.data_o    = r_data;
   assign bus.err       = r_err;
   // byte-lane write of accepted in-range writes; contents survive reset
   always_ff @(posedge clk) begin
      if (w_acc && bus.we && !w_oor)
         for (int i = 0; i < BYTES; i++)
            if (bus.sel[i]) r_mem[w_idx][i] <= bus.data_i[8*i +: 8];
   end
   // response slot: load on accept, drain on consume, hold while stalled
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_data  <= '0;
         r_err   <= 1'b0;
      end else if (w_acc) begin
         r_state <= FULL;
         r_data  <= (bus.we || w_oor) ? '0 : r_mem[w_idx];
         r_err   <= w_oor;
      end else if (r_state == FULL && bus.resp_ready) begin
         r_state <= IDLE;
      end
   end
endmodule

// File: tb/tb_data_ram_pipe.sv
// tb_data_ram_pipe: directed and random checks of data_ram_pipe against a byte-array model
module tb_data_ram_pipe;
   localparam int DW = 32, AW = 32, DL = 10, NB = 4, NBYTE = NB << DL;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int tests = 0, fails = 0;
   data_ram_pipe_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
   data_ram_pipe #(.DATA_W(DW), .ADDR_W(AW), .DEPTH_LOG2(DL)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   logic [7:0]  m_mem   [NBYTE];
   bit          m_known [NBYTE];
   bit          m_valid = 0, m_err = 0;
   logic [31:0] m_data = 0, m_mask = '1;
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
      end
   endtask
   // reference: a byte array plus one pending response slot
   always @(posedge clk) begin
      if (rst) begin
         m_valid = 0; m_err = 0; m_data = 0; m_mask = '1;
      end else if (bus.ce && (!m_valid || bus.resp_ready)) begin
         m_valid = 1; m_data = 0; m_mask = '1;
         m_err = bus.addr >= NBYTE;
         if (!m_err && bus.we) begin
            for (int i = 0; i < NB; i++)
               if (bus.sel[i]) begin
                  m_mem[(bus.addr / NB) * NB + i] = bus.data_i[8*i +: 8];
                  m_known[(bus.addr / NB) * NB + i] = 1;
               end
         end else if (!m_err) begin
            for (int i = 0; i < NB; i++) begin
               m_data[8*i +: 8] = m_mem[(bus.addr / NB) * NB + i];
               m_mask[8*i +: 8] = m_known[(bus.addr / NB) * NB + i] ? 8'hFF : 8'h00;
            end
         end
      end else if (m_valid && bus.resp_ready) begin
         m_valid = 0;
      end
   end
   always @(negedge clk) begin
      chk("rvalid", {31'b0, bus.rvalid}, {31'b0, m_valid});
      chk("req_ready", {31'b0, bus.req_ready}, {31'b0, !rst && (!m_valid || bus.resp_ready)});
      chk("err", {31'b0, bus.err}, {31'b0, m_err});
      chk("data_o", bus.data_o & m_mask, m_data & m_mask);
   end
   task automatic setin(input bit c, input bit w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, input bit rr);
      bus.ce = c; bus.we = w; bus.addr = a; bus.sel = s; bus.data_i = d; bus.resp_ready = rr;
   endtask
   task automatic step;
      @(posedge clk);
      #1;
   endtask
   task automatic chk_resp(input string n, input bit v, input bit e, input logic [31:0] d);
      chk({n, ".rvalid"}, {31'b0, bus.rvalid}, {31'b0, v});
      chk({n, ".err"}, {31'b0, bus.err}, {31'b0, e});
      chk({n, ".data"}, bus.data_o, d);
   endtask
   initial begin
      setin(1, 1, 32'h0, 4'hF, 32'hFFFF_FFFF, 1);
      step;
      step;
      chk_resp("reset", 0, 0, 0);
      chk("reset.req_ready", {31'b0, bus.req_ready}, 0);
      rst = 1'b0;
      setin(1, 1, 32'h00, 4'hF, 32'hA5A5_0001, 1); step;
      chk_resp("first_accept", 1, 0, 0);
      setin(1, 1, 32'h04, 4'hF, 32'h0B0B_0404, 1); step;
      setin(1, 1, 32'h08, 4'hF, 32'h0808_0808, 1); step;
      setin(1, 1, 32'h20, 4'hF, 32'hCAFE_F00D, 1); step;
      setin(1, 1, 32'h10, 4'hF, 32'hDEAD_BEEF, 1); step;
      chk_resp("wr_resp", 1, 0, 0);
      setin(1, 0, 32'h10, 4'h0, 32'h0, 1); step;
      chk_resp("rd_after_wr", 1, 0, 32'hDEAD_BEEF);
      setin(1, 1, 32'h10, 4'b0101, 32'h1122_3344, 1); step;
      setin(1, 0, 32'h13, 4'h0, 32'h0, 1); step;
      chk_resp("lane_merge", 1, 0, 32'hDE22_BE44);
      setin(0, 0, 32'h0, 4'h0, 32'h0, 1); step;
      chk("drain.rvalid", {31'b0, bus.rvalid}, 0);
      setin(1, 0, 32'h10, 4'hF, 32'h0, 0); step;
      setin(1, 0, 32'h20, 4'hF, 32'h0, 0);
      for (int k = 0; k < 3; k++) begin
         #1 chk("stall.req_ready", {31'b0, bus.req_ready}, 0);
         step;
         chk_resp("stall_hold", 1, 0, 32'hDE22_BE44);
      end
      setin(1, 0, 32'h20, 4'hF, 32'h0, 1);
      #1 chk("unstall.req_ready", {31'b0, bus.req_ready}, 1);
      step;
      chk_resp("unstall", 1, 0, 32'hCAFE_F00D);
      setin(1, 1, 32'h1000, 4'hF, 32'h1234_5678, 1); step;
      chk_resp("oor", 1, 1, 0);
      setin(1, 0, 32'h0, 4'hF, 32'h0, 1); step;
      chk_resp("after_oor", 1, 0, 32'hA5A5_0001);
      setin(1, 0, 32'h4, 4'hF, 32'h0, 0); step;
      rst = 1'b1;
      setin(1, 1, 32'h0, 4'hF, 32'hFFFF_FFFF, 1); step;
      chk_resp("mid_reset", 0, 0, 0);
      rst = 1'b0;
      setin(1, 0, 32'h0, 4'hF, 32'h0, 1); step;
      chk_resp("no_wr_in_rst", 1, 0, 32'hA5A5_0001);
      for (int k = 0; k < 3; k++) begin
         logic [31:0] exp [3];
         exp = '{32'hA5A5_0001, 32'h0B0B_0404, 32'h0808_0808};
         setin(1, 0, 32'(4 * k), 4'h0, 32'h0, 1);
         #1 chk("b2b.req_ready", {31'b0, bus.req_ready}, 1);
         step;
         chk_resp("b2b", 1, 0, exp[k]);
      end
      for (int k = 0; k < 3000; k++) begin
         rst = ($urandom_range(0, 149) == 0);
         setin($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
               ($urandom_range(0, 9) == 0) ? ($urandom | 32'h1000) : 32'($urandom_range(0, 63)),
               4'($urandom), $urandom, $urandom_range(0, 3) != 0);
         step;
      end
      rst = 1'b0;
      setin(0, 0, 32'h0, 4'h0, 32'h0, 1);
      step;
      step;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
